raster_sched: RTL

Triangle dispatcher and arbiter for the rasterizer. Two upstream triangle sources (e.g. vertex FIFO and clip-stage re-emit path) compete for the single rasterizer datapath. The block grants one triangle at a time round-robin and holds its three vertices stable on the rasterizer inputs. It pulses the start strobe and waits for rasterizer completion before issuing the next triangle, with an optional watchdog.

---
 rtl/raster_sched.sv | 116 +++++++++++
 1 files changed

// File: rtl/raster_sched.sv
// Round-robin triangle dispatcher: captures one of two sources, strobes the rasterizer, waits for done.
// Optional busy watchdog is compiled in with RASTER_SCHED_WATCHDOG_EN.
module raster_sched #(
  parameter int VERTEX_TYPE_SIZE = 96,
  parameter int TIMEOUT_CYCLES   = 65536
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  req_valid,
  input  logic [VERTEX_TYPE_SIZE-1:0] req0_v1,
  input  logic [VERTEX_TYPE_SIZE-1:0] req0_v2,
  input  logic [VERTEX_TYPE_SIZE-1:0] req0_v3,
  input  logic [VERTEX_TYPE_SIZE-1:0] req1_v1,
  input  logic [VERTEX_TYPE_SIZE-1:0] req1_v2,
  input  logic [VERTEX_TYPE_SIZE-1:0] req1_v3,
  output logic [1:0]                  req_ack,
  output logic [VERTEX_TYPE_SIZE-1:0] rast_v1,
  output logic [VERTEX_TYPE_SIZE-1:0] rast_v2,
  output logic [VERTEX_TYPE_SIZE-1:0] rast_v3,
  output logic                        rast_start,
  input  logic                        rast_done,
  output logic                        busy,
  output logic                        grant_id,
  output logic [31:0]                 tri_count,
  output logic                        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t state;
  logic   last_grant;
  logic   done_q;
  logic   done_edge;
  logic   grant_pick;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign done_edge  = rast_done & ~done_q;
  // Source 1 wins when it is alone, or on a tie when source 0 was granted last.
  assign grant_pick = req_valid[1] & (~req_valid[0] | ~last_grant);

`ifdef RASTER_SCHED_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_cnt;
  logic        timeout_reg;
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ack    <= '0;
      rast_start <= 1'b0;
      busy       <= 1'b0;
      rast_v1    <= '0;
      rast_v2    <= '0;
      rast_v3    <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      tri_count  <= '0;
      done_q     <= 1'b0;
`ifdef RASTER_SCHED_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      done_q     <= rast_done;
      req_ack    <= '0;
      rast_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            rast_v1    <= grant_pick ? req1_v1 : req0_v1;
            rast_v2    <= grant_pick ? req1_v2 : req0_v2;
            rast_v3    <= grant_pick ? req1_v3 : req0_v3;
            grant_id   <= grant_pick;
            last_grant <= grant_pick;
            req_ack    <= grant_pick ? 2'b10 : 2'b01;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          rast_start <= 1'b1;
          state      <= BUSY;
`ifdef RASTER_SCHED_WATCHDOG_EN
          wd_cnt     <= '0;
`endif
        end
        BUSY: begin
          if (done_edge) begin
            tri_count <= tri_count + 32'd1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
`ifdef RASTER_SCHED_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            // Abandon the triangle; it is neither counted nor retried.
            timeout_reg <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
